// File: rtl/des_pkg.sv
// Shared DES datapath types and P-box index tables.
// P_INV_TABLE: out[j] = in[Q[j]]; P_FWD_TABLE: its inverse.
package des_pkg;

  typedef logic [31:0] word32_t;

  typedef enum logic [1:0] {
    SK_EMPTY,
    SK_ONE,
    SK_FULL
  } skid_st_e;

  localparam logic [4:0] P_INV_TABLE [32] = '{
    5'd23, 5'd15, 5'd9,  5'd1,  5'd19, 5'd4,  5'd30, 5'd14,
    5'd8,  5'd16, 5'd2,  5'd26, 5'd6,  5'd12, 5'd22, 5'd31,
    5'd24, 5'd18, 5'd7,  5'd29, 5'd28, 5'd3,  5'd21, 5'd13,
    5'd0,  5'd20, 5'd10, 5'd25, 5'd27, 5'd5,  5'd17, 5'd11
  };

  localparam logic [4:0] P_FWD_TABLE [32] = '{
    5'd24, 5'd3,  5'd10, 5'd21, 5'd5,  5'd29, 5'd12, 5'd18,
    5'd8,  5'd2,  5'd26, 5'd31, 5'd13, 5'd23, 5'd7,  5'd1,
    5'd9,  5'd30, 5'd17, 5'd4,  5'd25, 5'd22, 5'd14, 5'd0,
    5'd16, 5'd27, 5'd11, 5'd28, 5'd20, 5'd19, 5'd6,  5'd15
  };

endpackage

// File: rtl/p_box_inv_32_32.sv
// Combinational inverse DES P permutation.
// Ports: din (forward-permuted word), dout (restored word).
module p_box_inv_32_32
  import des_pkg::*;
(
  input  logic [31:0] din,
  output logic [31:0] dout
);

  always_comb begin
    dout = '0;
    for (int j = 0; j < 32; j++) begin
      dout[j] = din[P_INV_TABLE[j]];
    end
  end

endmodule

// File: rtl/p_box_inv_32_32_pipe.sv
// Streaming inverse DES P-box: 2-entry skid, PIPE_STAGES (1|2) regs.
// Ports: clk, rst_n, in_valid/in_ready/in_data, out_valid/out_ready/
// out_data, busy. P_BOX_INV_PARITY_EN adds in_par, out_par, par_err.
module p_box_inv_32_32_pipe
  import des_pkg::*;
#(
  parameter int PIPE_STAGES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
`ifdef P_BOX_INV_PARITY_EN
  input  logic        in_par,
  output logic        out_par,
  output logic        par_err,
`endif
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        busy
);

`ifdef P_BOX_INV_PARITY_EN
  localparam int BW = 33;
`else
  localparam int BW = 32;
`endif

  word32_t perm;

  p_box_inv_32_32 u_perm (
    .din  (in_data),
    .dout (perm)
  );

  logic [BW-1:0] beat_in;

`ifdef P_BOX_INV_PARITY_EN
  assign beat_in = {in_par, perm};
`else
  assign beat_in = perm;
`endif

  skid_st_e      state, state_n;
  logic [BW-1:0] e0, e1;
  logic          rdy_q;
  logic          acc, push, pop;
  logic          src_v;
  logic [BW-1:0] src_d;
  logic          en0;
  logic          s0_v;
  logic [BW-1:0] s0_d;
  logic          last_v;
  logic [BW-1:0] last_d;
  logic          pipe_busy;

  // Skid head feeds the pipe first; an empty skid lets the
  // incoming word bypass straight into stage 0.
  always_comb begin
    acc     = in_valid & rdy_q;
    src_v   = (state != SK_EMPTY) | acc;
    src_d   = (state != SK_EMPTY) ? e0 : beat_in;
    pop     = (state != SK_EMPTY) & en0;
    push    = acc & ((state != SK_EMPTY) | ~en0);
    state_n = state;
    unique case (state)
      SK_EMPTY: if (push) state_n = SK_ONE;
      SK_ONE: begin
        if (push && !pop) state_n = SK_FULL;
        else if (pop && !push) state_n = SK_EMPTY;
      end
      SK_FULL: if (pop) state_n = SK_ONE;
      default: state_n = SK_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= SK_EMPTY;
      rdy_q <= 1'b0;
    end else begin
      state <= state_n;
      rdy_q <= (state_n != SK_FULL);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e0 <= '0;
      e1 <= '0;
    end else if (push && pop) begin
      e0 <= beat_in;
    end else if (pop) begin
      e0 <= e1;
    end else if (push) begin
      if (state == SK_EMPTY) e0 <= beat_in;
      else e1 <= beat_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s0_v <= 1'b0;
      s0_d <= '0;
    end else if (en0) begin
      s0_v <= src_v;
      if (src_v) s0_d <= src_d;
    end
  end

  generate
    if (PIPE_STAGES == 2) begin : g_two
      logic          en1;
      logic          s1_v;
      logic [BW-1:0] s1_d;

      assign en1 = ~s1_v | out_ready;
      assign en0 = ~s0_v | en1;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          s1_v <= 1'b0;
          s1_d <= '0;
        end else if (en1) begin
          s1_v <= s0_v;
          if (s0_v) s1_d <= s0_d;
        end
      end

      assign last_v    = s1_v;
      assign last_d    = s1_d;
      assign pipe_busy = s0_v | s1_v;
    end else begin : g_one
      assign en0       = ~s0_v | out_ready;
      assign last_v    = s0_v;
      assign last_d    = s0_d;
      assign pipe_busy = s0_v;
    end
  endgenerate

  assign in_ready  = rdy_q;
  assign out_valid = last_v;
  assign out_data  = last_d[31:0];
  assign busy      = pipe_busy | (state != SK_EMPTY);

`ifdef P_BOX_INV_PARITY_EN
  assign out_par = last_d[32];

  // Permutation preserves parity, so checking the raw input suffices.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) par_err <= 1'b0;
    else if (acc && (in_par != ^in_data)) par_err <= 1'b1;
  end
`endif

endmodule
